// File: rtl/rr_interval_if.sv
// Signal bundle between the R-peak detector and the RR-interval stage.
// The detector side drives r_peak; the interval stage drives every measurement output.
interface rr_interval_if #(
   parameter int CNT_W = 12
);
   logic             r_peak;
   logic             beat;
   logic [CNT_W-1:0] rr_out;
   logic             rr_valid;
   logic [CNT_W-1:0] rr_avg;
   logic             avg_valid;
   logic             asystole;
   logic             reject;

   modport master (
      output r_peak,
      input  beat, rr_out, rr_valid, rr_avg, avg_valid, asystole, reject
   );

   modport slave (
      input  r_peak,
      output beat, rr_out, rr_valid, rr_avg, avg_valid, asystole, reject
   );
endinterface

// File: rtl/rr_interval.sv
// Beat-to-beat interval measurement with refractory blanking, asystole timeout
// and a running average over the last four intervals (one clk = one ECG sample).
module rr_interval #(
   parameter int CNT_W   = 12,
   parameter int REFRACT = 50,
   parameter int MAX_RR  = 500
) (
   input  logic         clk,
   input  logic         rst,
   rr_interval_if.slave bus
);
   typedef enum logic [1:0] {IDLE, REFR, RUN} state_t;

   localparam logic [CNT_W-1:0] REFR_LAST = CNT_W'(REFRACT - 1);
   localparam logic [CNT_W-1:0] MAX_C     = CNT_W'(MAX_RR);
   localparam logic [CNT_W-1:0] MAX_LAST  = CNT_W'(MAX_RR - 1);

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   r_q;
   logic                   pk_edge;
   logic                   accept, refr_rej, timeout, measure;

   logic [CNT_W-1:0]       hist_q [0:3];
   logic [CNT_W+1:0]       sum_q, sum_d;
   logic [2:0]             fill_q;

   logic                   beat_q, rr_valid_q, reject_q, avg_valid_q, asystole_q;
   logic [CNT_W-1:0]       rr_out_q, rr_avg_q;

   assign pk_edge = bus.r_peak & ~r_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         r_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         r_q     <= bus.r_peak;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (pk_edge) state_d = REFR;
         REFR:    if (!pk_edge && cnt_q >= REFR_LAST) state_d = RUN;
         RUN:     if (pk_edge) state_d = REFR;
                  else if (cnt_q >= MAX_LAST) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Decision strobes; the timeout fires on the cycle the counter would reach MAX_RR, and an edge there wins.
   always_comb begin
      accept   = 1'b0;
      refr_rej = 1'b0;
      timeout  = 1'b0;
      case (state_q)
         IDLE:    accept = pk_edge;
         REFR:    refr_rej = pk_edge;
         RUN:     if (pk_edge) accept = 1'b1;
                  else if (cnt_q >= MAX_LAST) timeout = 1'b1;
         default: ;
      endcase
   end

   assign measure = accept && (state_q == RUN);

   always_comb begin
      cnt_d = cnt_q;
      if (accept)
         cnt_d = CNT_W'(1);
      else if (state_q != IDLE && cnt_q < MAX_C)
         cnt_d = cnt_q + CNT_W'(1);
   end

   // Slot 3 is the oldest interval; it reads zero until four have been pushed.
   assign sum_d = sum_q + {2'b00, cnt_q} - {2'b00, hist_q[3]};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 4; i++) hist_q[i] <= '0;
         sum_q       <= '0;
         fill_q      <= '0;
         beat_q      <= 1'b0;
         rr_valid_q  <= 1'b0;
         reject_q    <= 1'b0;
         avg_valid_q <= 1'b0;
         asystole_q  <= 1'b0;
         rr_out_q    <= '0;
         rr_avg_q    <= '0;
      end else begin
         beat_q     <= accept;
         rr_valid_q <= measure;
         reject_q   <= refr_rej;
         if (accept) asystole_q <= 1'b0;
         if (measure) begin
            hist_q[0] <= cnt_q;
            for (int i = 1; i < 4; i++) hist_q[i] <= hist_q[i-1];
            sum_q       <= sum_d;
            rr_out_q    <= cnt_q;
            rr_avg_q    <= sum_d[CNT_W+1:2];
            fill_q      <= (fill_q == 3'd4) ? 3'd4 : fill_q + 3'd1;
            avg_valid_q <= (fill_q >= 3'd3);
         end else if (timeout) begin
            for (int i = 0; i < 4; i++) hist_q[i] <= '0;
            sum_q       <= '0;
            fill_q      <= '0;
            avg_valid_q <= 1'b0;
            rr_avg_q    <= '0;
            asystole_q  <= 1'b1;
         end
      end
   end

   assign bus.beat      = beat_q;
   assign bus.rr_valid  = rr_valid_q;
   assign bus.reject    = reject_q;
   assign bus.rr_out    = rr_out_q;
   assign bus.rr_avg    = rr_avg_q;
   assign bus.avg_valid = avg_valid_q;
   assign bus.asystole  = asystole_q;
endmodule

// File: tb/tb_rr_interval.sv
// Directed bench for rr_interval: hand-computed intervals, averages, refractory,
// asystole timeout and asynchronous reset behaviour.
module tb_rr_interval;
   localparam int CNT_W = 12;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   tests = 0;
   int   fails = 0;
   int   nbeat;

   rr_interval_if #(.CNT_W(CNT_W)) bus ();

   rr_interval #(.CNT_W(CNT_W), .REFRACT(50), .MAX_RR(500)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse();
      bus.r_peak = 1'b1;
      tick(1);
      bus.r_peak = 1'b0;
      $display("[TB] t=%0t pulse beat=%0b rr_valid=%0b rr_out=%0d rr_avg=%0d avg_valid=%0b reject=%0b",
               $time, bus.beat, bus.rr_valid, bus.rr_out, bus.rr_avg, bus.avg_valid, bus.reject);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick(2);
      rst = 1'b1;
   endtask

   int ivs      [8] = '{100, 200, 300, 400, 100, 101, 102, 103};
   int exp_avg  [8] = '{25, 75, 150, 250, 250, 225, 175, 101};
   int exp_aval [8] = '{0, 0, 0, 1, 1, 1, 1, 1};

   initial begin
      bus.r_peak = 1'b0;
      tick(3);
      check("rst_beat", bus.beat, 0);
      check("rst_rr_out", bus.rr_out, 0);
      check("rst_avg_valid", bus.avg_valid, 0);
      check("rst_asystole", bus.asystole, 0);
      rst = 1'b1;

      // Five beats 200 cycles apart
      tick(99);
      for (int i = 0; i < 5; i++) begin
         pulse();
         check("t1_beat", bus.beat, 1);
         check("t1_rr_valid", bus.rr_valid, (i > 0) ? 1 : 0);
         if (i > 0) check("t1_rr_out", bus.rr_out, 200);
         if (i == 3) begin
            check("t1_avg_valid_b4", bus.avg_valid, 0);
            check("t1_rr_avg_b4", bus.rr_avg, 150);
         end
         if (i < 4) tick(199);
      end
      check("t1_avg_valid", bus.avg_valid, 1);
      check("t1_rr_avg", bus.rr_avg, 200);
      check("t1_asystole", bus.asystole, 0);
      tick(1);
      check("t1_beat_pulse", bus.beat, 0);
      check("t1_rr_valid_pulse", bus.rr_valid, 0);

      // Refractory reject then interval spanning the rejected edge
      do_reset();
      pulse();
      check("t2_first_rr_valid", bus.rr_valid, 0);
      tick(199);
      pulse();
      check("t2_rr_out200", bus.rr_out, 200);
      tick(19);
      pulse();
      check("t2_reject", bus.reject, 1);
      check("t2_rej_beat", bus.beat, 0);
      check("t2_rej_rr_valid", bus.rr_valid, 0);
      tick(1);
      check("t2_reject_pulse", bus.reject, 0);
      tick(198);
      pulse();
      check("t2_rr_out220", bus.rr_out, 220);

      // Running average, then silence into asystole
      do_reset();
      pulse();
      for (int i = 0; i < 8; i++) begin
         tick(ivs[i] - 1);
         pulse();
         check("t4_rr_out", bus.rr_out, ivs[i]);
         check("t4_rr_avg", bus.rr_avg, exp_avg[i]);
         check("t4_avg_valid", bus.avg_valid, exp_aval[i]);
      end
      tick(498);
      check("t3_asystole_early", bus.asystole, 0);
      tick(1);
      check("t3_asystole", bus.asystole, 1);
      check("t3_avg_valid_clr", bus.avg_valid, 0);
      check("t3_rr_avg_clr", bus.rr_avg, 0);
      check("t3_rr_out_hold", bus.rr_out, 103);
      tick(20);
      pulse();
      check("t3_beat", bus.beat, 1);
      check("t3_asystole_clr", bus.asystole, 0);
      check("t3_rr_valid", bus.rr_valid, 0);
      tick(299);
      pulse();
      check("t3_rr_out300", bus.rr_out, 300);
      check("t3_rr_avg75", bus.rr_avg, 75);
      check("t3_avg_valid0", bus.avg_valid, 0);

      // Refractory boundary: 50 accepted, 49 rejected
      do_reset();
      pulse();
      tick(49);
      pulse();
      check("t5_beat50", bus.beat, 1);
      check("t5_rr_out50", bus.rr_out, 50);
      tick(48);
      pulse();
      check("t5_reject49", bus.reject, 1);
      check("t5_beat49", bus.beat, 0);

      // Held r_peak, async reset mid-interval, r_peak high across reset release
      do_reset();
      bus.r_peak = 1'b1;
      tick(1);
      check("t6_held_beat", bus.beat, 1);
      nbeat = 0;
      for (int i = 0; i < 9; i++) begin
         tick(1);
         nbeat += int'(bus.beat);
      end
      check("t6_held_extra_beats", nbeat, 0);
      bus.r_peak = 1'b0;
      tick(90);
      pulse();
      check("t6_rr_out100", bus.rr_out, 100);
      tick(30);
      #2;
      bus.r_peak = 1'b1;
      rst = 1'b0;
      #1;
      check("t6_async_rr_out", bus.rr_out, 0);
      check("t6_async_rr_avg", bus.rr_avg, 0);
      check("t6_async_beat", bus.beat, 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      tick(1);
      bus.r_peak = 1'b0;
      check("t6_first_beat", bus.beat, 1);
      check("t6_first_rr_valid", bus.rr_valid, 0);
      tick(59);
      pulse();
      check("t6_rr_out60", bus.rr_out, 60);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/rr_interval.md
Name: rr_interval

Overview:
Downstream stage of the R-peak detector. Consumes the detector's R-peak flag and measures beat-to-beat (RR) intervals in clock cycles, where one clk equals one ECG sample. Applies a refractory blanking window and a running 4-beat average. Flags asystole when no beat arrives within a maximum interval. Outputs feed the heart-rate display/alarm logic.

Parameters:
CNT_W, 12, width of the interval counter and all interval outputs
REFRACT, 50, minimum accepted RR in cycles; edges with interval < REFRACT are rejected
MAX_RR, 500, timeout in cycles; must satisfy REFRACT < MAX_RR < 2^CNT_W

Ports:
clk  input  1  sample clock; all logic on rising edge
rst  input  1  reset, asynchronous assert, active-low (0 = reset)
r_peak  input  1  R-peak flag from detector; may stay high for multiple cycles
beat  output  1  one-cycle pulse per accepted beat
rr_out  output  CNT_W  last measured RR interval in cycles
rr_valid  output  1  one-cycle pulse when rr_out is updated
rr_avg  output  CNT_W  mean of last 4 intervals (sum >> 2, truncated)
avg_valid  output  1  level; high once 4 intervals are held since reset/timeout
asystole  output  1  level; high after a timeout until the next accepted beat
reject  output  1  one-cycle pulse when an edge is discarded as refractory

Behaviour:
- Reset (rst=0, async): state=IDLE, cnt=0, r_q=0, history and sum cleared; all outputs 0.
- Edge detect: r_q registers r_peak. edge = r_peak & ~r_q. Only edges count; a held-high r_peak produces exactly one edge.
- cnt: on an accepted edge cnt<=1. Otherwise, in REFR/RUN, cnt<=cnt+1, saturating at MAX_RR. At an edge, cnt equals the cycles since the previous accepted edge.
- States:
  - IDLE: no reference beat held. On edge -> REFR, beat=1, cnt<=1, asystole<=0, no rr_valid.
  - REFR: on edge, reject=1 with no other effect. When cnt reaches REFRACT-1 with no edge -> RUN, so the edge at interval = REFRACT is accepted.
  - RUN, edge with cnt < MAX_RR: accept.
    - beat=1, rr_valid=1, rr_out<=cnt, push cnt into 4-entry history, cnt<=1 -> REFR.
  - RUN, cnt reaches MAX_RR with no edge: asystole<=1.
    - Clear history, sum, avg_valid and rr_avg; rr_out holds its value -> IDLE.
  - Edge in the same cycle cnt would reach MAX_RR: accept (edge wins).
- Latency: beat, rr_valid, rr_out, reject, rr_avg and avg_valid are registered. Each updates on the clock edge that samples edge=1, so they are visible in the cycle after r_peak first goes high.
- Average arithmetic:
  - sum is CNT_W+2 bits. On push: sum_next = sum + new - oldest.
  - The oldest entry is 0 while fewer than 4 entries are held.
  - rr_avg <= sum_next[CNT_W+1:2], updated together with rr_valid.
  - avg_valid goes high together with the 4th rr_valid.
- Reset mid-operation: immediate return to reset values; no partial interval is reported.
- r_peak high during reset and still high after release: r_q=0 at release, so this counts as one edge. Accepted in IDLE.

Test Plan:
- Reset release, then r_peak pulses at cycles 100, 300, 500, 700, 900 -> beat on each. rr_valid with rr_out=200 on beats 2-5. avg_valid high at the 5th beat with rr_avg=200. asystole=0.
- Beats at 0, 200, then a second edge 20 cycles after the 200 beat -> reject pulse, no beat or rr_valid. Next edge at 420 -> rr_out=220.
- Single beat then silence -> asystole=1 exactly MAX_RR=500 cycles after the beat, avg_valid=0. Next edge -> beat=1, asystole=0, no rr_valid. Following edge at +300 -> rr_out=300.
- Intervals 100, 200, 300, 400, 501-clamped case excluded; then 4 intervals 100, 101, 102, 103 -> rr_avg=101 (406>>2).
- Edge exactly at interval 50 -> accepted (rr_out=50). Edge at interval 49 -> reject.
- r_peak held high for 10 cycles -> one beat. Assert rst=0 asynchronously mid-interval -> all outputs 0 immediately. Next edge is treated as the first beat.
